// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : trap_sequencer
// Brief    : Arbitrates sync exceptions, xRET and interrupts, then sequences
//            the csr trap update. Optional DRAIN watchdog: TRAP_SEQUENCER_WDOG_EN.
// Revision : 1.0
// ============================================================================
module trap_sequencer #(
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_req,
  input  logic [62:0] exc_cause,
  input  logic [63:0] exc_tval,
  input  logic [63:0] exc_pc,
  input  logic        mret_req,
  input  logic        sret_req,
  input  logic [11:0] irq_pend,
  input  logic [11:0] mideleg,
  input  logic        mstatus_mie,
  input  logic        mstatus_sie,
  input  logic [1:0]  mode,
  input  logic        pipe_drained,
  output logic        evt_ack,
  output logic        stall,
  output logic        flush,
  output logic        exception,
  output logic        interrupt,
  output logic        mret,
  output logic        sret,
  output logic [62:0] causecode,
  output logic [63:0] tval,
  output logic [63:0] trap_pc,
  output logic        redirect,
`ifdef TRAP_SEQUENCER_WDOG_EN
  output logic        wdog_err,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_EXC  = 2'd0,
    K_MRET = 2'd1,
    K_SRET = 2'd2,
    K_IRQ  = 2'd3
  } kind_t;

  state_t      r_state;
  state_t      w_next;
  kind_t       r_kind;
  logic [62:0] r_cause;
  logic [63:0] r_tval;
  logic [63:0] r_pc;
  logic        r_irq;

  logic        w_m_ok;
  logic        w_s_ok;
  logic [11:0] w_irq_en;
  logic        w_irq_any;
  logic [3:0]  w_irq_id;
  logic        w_any_req;
  logic        w_accept;
  logic        w_wdog_fire;

  // Delegated interrupts target S-mode and can never preempt M-mode.
  assign w_m_ok   = (mode != 2'd3) | mstatus_mie;
  assign w_s_ok   = (mode == 2'd0) | ((mode == 2'd1) & mstatus_sie);
  assign w_irq_en = irq_pend & ((~mideleg & {12{w_m_ok}}) | (mideleg & {12{w_s_ok}}));

  always_comb begin
    w_irq_any = 1'b1;
    w_irq_id  = 4'd0;
    if (w_irq_en[11])     w_irq_id = 4'd11;
    else if (w_irq_en[3]) w_irq_id = 4'd3;
    else if (w_irq_en[7]) w_irq_id = 4'd7;
    else if (w_irq_en[9]) w_irq_id = 4'd9;
    else if (w_irq_en[1]) w_irq_id = 4'd1;
    else if (w_irq_en[5]) w_irq_id = 4'd5;
    else                  w_irq_any = 1'b0;
  end

  assign w_any_req = exc_req | mret_req | sret_req | w_irq_any;
  assign w_accept  = (r_state == S_IDLE) & w_any_req;

`ifdef TRAP_SEQUENCER_WDOG_EN
  localparam int c_cnt_w = $clog2(DRAIN_TIMEOUT + 1);

  logic [c_cnt_w-1:0] r_drain_cnt;
  logic               r_wdog_err;

  // r_drain_cnt holds the number of completed DRAIN cycles.
  assign w_wdog_fire = (r_state == S_DRAIN) & ~pipe_drained &
                       (r_drain_cnt == c_cnt_w'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drain_cnt <= '0;
      r_wdog_err  <= 1'b0;
    end else begin
      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
      else                    r_drain_cnt <= '0;
      if (w_wdog_fire)        r_wdog_err  <= 1'b1;
    end
  end

  assign wdog_err = r_wdog_err;
`else
  assign w_wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    evt_ack   = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    exception = 1'b0;
    mret      = 1'b0;
    sret      = 1'b0;
    redirect  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated so a request held through reset is not acknowledged.
        evt_ack = w_accept & ~reset;
        if (w_accept) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        stall = 1'b1;
        flush = 1'b1;
        if (pipe_drained | w_wdog_fire) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        stall     = 1'b1;
        exception = (r_kind == K_EXC) | (r_kind == K_IRQ);
        mret      = (r_kind == K_MRET);
        sret      = (r_kind == K_SRET);
        w_next    = S_REDIRECT;
      end
      S_REDIRECT: begin
        stall    = 1'b1;
        redirect = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // xRET leaves the cause register untouched; only tval is cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kind  <= K_EXC;
      r_cause <= '0;
      r_tval  <= '0;
      r_pc    <= '0;
      r_irq   <= 1'b0;
    end else if (w_accept) begin
      r_pc <= exc_pc;
      if (exc_req) begin
        r_kind  <= K_EXC;
        r_cause <= exc_cause;
        r_tval  <= exc_tval;
        r_irq   <= 1'b0;
      end else if (mret_req) begin
        r_kind <= K_MRET;
        r_tval <= '0;
        r_irq  <= 1'b0;
      end else if (sret_req) begin
        r_kind <= K_SRET;
        r_tval <= '0;
        r_irq  <= 1'b0;
      end else begin
        r_kind  <= K_IRQ;
        r_cause <= {59'd0, w_irq_id};
        r_tval  <= '0;
        r_irq   <= 1'b1;
      end
    end
  end

  assign interrupt = r_irq;
  assign causecode = r_cause;
  assign tval      = r_tval;
  assign trap_pc   = r_pc;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// Bench for trap_sequencer: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a timeline-based reference model.
module tb_trap_sequencer;

  localparam int DRAIN_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exc_req = 1'b0;
  logic [62:0] exc_cause = '0;
  logic [63:0] exc_tval = '0;
  logic [63:0] exc_pc = '0;
  logic        mret_req = 1'b0;
  logic        sret_req = 1'b0;
  logic [11:0] irq_pend = '0;
  logic [11:0] mideleg = '0;
  logic        mstatus_mie = 1'b0;
  logic        mstatus_sie = 1'b0;
  logic [1:0]  mode = 2'd3;
  logic        pipe_drained = 1'b1;
  logic        evt_ack, stall, flush, exception, interrupt, mret, sret, redirect, busy;
  logic [62:0] causecode;
  logic [63:0] tval, trap_pc;
`ifdef TRAP_SEQUENCER_WDOG_EN
  logic        wdog_err;
`endif

  trap_sequencer #(.DRAIN_TIMEOUT(DRAIN_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .exc_cause(exc_cause),
    .exc_tval(exc_tval), .exc_pc(exc_pc), .mret_req(mret_req), .sret_req(sret_req),
    .irq_pend(irq_pend), .mideleg(mideleg), .mstatus_mie(mstatus_mie),
    .mstatus_sie(mstatus_sie), .mode(mode), .pipe_drained(pipe_drained),
    .evt_ack(evt_ack), .stall(stall), .flush(flush), .exception(exception),
    .interrupt(interrupt), .mret(mret), .sret(sret), .causecode(causecode),
    .tval(tval), .trap_pc(trap_pc), .redirect(redirect),
`ifdef TRAP_SEQUENCER_WDOG_EN
    .wdog_err(wdog_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Highest-priority enabled interrupt, or -1.
  function automatic int irq_pick(input logic [11:0] pend, input logic [11:0] deleg,
                                  input logic mie, input logic sie, input logic [1:0] md);
    int order [6];
    order = '{11, 3, 7, 9, 1, 5};
    for (int i = 0; i < 6; i++) begin
      int n;
      bit ok;
      n = order[i];
      if (deleg[n]) ok = (md == 2'd0) || (md == 2'd1 && sie);
      else          ok = (md != 2'd3) || mie;
      if (pend[n] && ok) return n;
    end
    return -1;
  endfunction

  // Reference model: an accepted event plus the cycles at which it commits and redirects.
  bit          m_active = 0;
  longint      m_commit_cyc = -1;
  longint      m_redir_cyc = -1;
  int          m_kind = 0;   // 0 exc, 1 mret, 2 sret, 3 irq
  logic [62:0] m_cause = '0;
  logic [63:0] m_tval = '0;
  logic [63:0] m_pc = '0;
  bit          m_irq = 0;
  bit          m_acked = 0;
  int          m_drain_cnt = 0;
  bit          m_wdog = 0;

  bit          ack_flag, exc_flag, mret_flag, redir_flag;
  longint      ack_cyc, exc_cyc, redir_cyc;
  logic [62:0] cap_cause, cap_mret_cause;
  logic [63:0] cap_tval, cap_pc;
  logic        cap_irq;

  always @(negedge clk) begin
    bit e_idle, e_drain, e_commit, e_redir, e_ack;
    int win, n;
    if (evt_ack) begin ack_flag = 1; ack_cyc = cyc; end
    if (exception) begin
      exc_flag = 1; exc_cyc = cyc; cap_cause = causecode;
      cap_tval = tval; cap_pc = trap_pc; cap_irq = interrupt;
    end
    if (mret) begin mret_flag = 1; cap_mret_cause = causecode; end
    if (redirect) begin redir_flag = 1; redir_cyc = cyc; end

    if (reset) begin
      m_active = 0; m_commit_cyc = -1; m_redir_cyc = -1; m_kind = 0;
      m_cause = '0; m_tval = '0; m_pc = '0; m_irq = 0; m_acked = 0; m_wdog = 0;
      chk("rst_evt_ack", 64'(evt_ack), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_flush", 64'(flush), 64'd0);
      chk("rst_strobes", 64'({exception, mret, sret, redirect}), 64'd0);
      chk("rst_interrupt", 64'(interrupt), 64'd0);
      chk("rst_causecode", 64'(causecode), 64'd0);
      chk("rst_tval", tval, 64'd0);
      chk("rst_trap_pc", trap_pc, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end else begin
      e_idle   = !m_active;
      e_drain  = m_active && (m_commit_cyc < 0);
      e_commit = m_active && (cyc == m_commit_cyc);
      e_redir  = m_active && (cyc == m_redir_cyc);
      n   = irq_pick(irq_pend, mideleg, mstatus_mie, mstatus_sie, mode);
      win = -1;
      if (e_idle) begin
        if (exc_req)       win = 0;
        else if (mret_req) win = 1;
        else if (sret_req) win = 2;
        else if (n >= 0)   win = 3;
      end
      e_ack = (win >= 0);

      chk("evt_ack", 64'(evt_ack), 64'(e_ack));
      chk("stall", 64'(stall), 64'(!e_idle));
      chk("flush", 64'(flush), 64'(e_drain));
      chk("exception", 64'(exception), 64'(e_commit && (m_kind == 0 || m_kind == 3)));
      chk("mret", 64'(mret), 64'(e_commit && m_kind == 1));
      chk("sret", 64'(sret), 64'(e_commit && m_kind == 2));
      chk("redirect", 64'(redirect), 64'(e_redir));
      chk("busy", 64'(busy), 64'(!e_idle));
      chk("interrupt", 64'(interrupt), 64'(m_irq));
      chk("causecode", 64'(causecode), 64'(m_cause));
      chk("tval", tval, m_tval);
      chk("trap_pc", trap_pc, m_pc);
`ifdef TRAP_SEQUENCER_WDOG_EN
      chk("wdog_err", 64'(wdog_err), 64'(m_wdog));
`endif

      m_acked = e_ack;
      if (e_ack) begin
        m_active = 1; m_commit_cyc = -1; m_redir_cyc = -1; m_drain_cnt = 0;
        m_kind = win; m_pc = exc_pc;
        if (win == 0) begin m_cause = exc_cause; m_tval = exc_tval; m_irq = 0; end
        else if (win == 3) begin m_cause = 63'(n); m_tval = '0; m_irq = 1; end
        else begin m_tval = '0; m_irq = 0; end
      end else if (e_drain) begin
        m_drain_cnt++;
        if (pipe_drained) begin m_commit_cyc = cyc + 1; m_redir_cyc = cyc + 2; end
`ifdef TRAP_SEQUENCER_WDOG_EN
        else if (m_drain_cnt == DRAIN_TIMEOUT) begin
          m_commit_cyc = cyc + 1; m_redir_cyc = cyc + 2; m_wdog = 1;
        end
`endif
      end else if (e_redir) begin
        m_active = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    ack_flag = 0; exc_flag = 0; mret_flag = 0; redir_flag = 0;
  endtask

  // Requests must already be driven; waits for ack, drops them, waits for redirect.
  task automatic run_event(input string tag);
    bit got;
    clear_flags();
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin step(); got = ack_flag; end
    chk({tag, "_ack_seen"}, 64'(got), 64'd1);
    exc_req = 0; mret_req = 0; sret_req = 0; irq_pend = '0;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin step(); got = redir_flag; end
    chk({tag, "_redirect_seen"}, 64'(got), 64'd1);
    step();
  endtask

  initial begin
    logic [63:0] t;
    repeat (3) step();
    reset = 0;
    step();

    mret_req = 1; exc_pc = 64'h8000_0100;
    run_event("mret_only");
    chk("mret_only_strobe", 64'(mret_flag), 64'd1);
    chk("mret_only_no_exc", 64'(exc_flag), 64'd0);
    chk("mret_only_cause", 64'(cap_mret_cause), 64'd0);

    exc_req = 1; exc_cause = 63'd2; exc_tval = 64'hDEAD; exc_pc = 64'h8000_0010;
    run_event("exc");
    chk("exc_latency", 64'(exc_cyc - ack_cyc), 64'd2);
    chk("redirect_latency", 64'(redir_cyc - ack_cyc), 64'd3);
    chk("exc_cause", 64'(cap_cause), 64'd2);
    chk("exc_tval", cap_tval, 64'hDEAD);
    chk("exc_pc", cap_pc, 64'h8000_0010);
    chk("exc_not_irq", 64'(cap_irq), 64'd0);

    exc_req = 1; mret_req = 1; exc_cause = 63'd5; exc_tval = 64'h44; exc_pc = 64'h8000_0200;
    run_event("exc_mret");
    chk("exc_mret_exc", 64'(exc_flag), 64'd1);
    chk("exc_mret_no_mret", 64'(mret_flag), 64'd0);
    chk("exc_mret_cause", 64'(cap_cause), 64'd5);

    mode = 2'd0; mideleg = '0; irq_pend = 12'h8A2;
    run_event("irq_a");
    chk("irq_a_cause", 64'(cap_cause), 64'd11);
    chk("irq_a_flag", 64'(cap_irq), 64'd1);
    chk("irq_a_tval", cap_tval, 64'd0);
    irq_pend = 12'h0A2;
    run_event("irq_b");
    chk("irq_b_cause", 64'(cap_cause), 64'd7);

    mode = 2'd3; mstatus_mie = 0; irq_pend = 12'h080;
    clear_flags();
    repeat (20) step();
    chk("mmode_masked", 64'(ack_flag), 64'd0);
    mstatus_mie = 1;
    run_event("mmode_mie");
    chk("mmode_mie_cause", 64'(cap_cause), 64'd7);

    mode = 2'd1; mstatus_mie = 0; mideleg = 12'h200; mstatus_sie = 0; irq_pend = 12'h200;
    clear_flags();
    repeat (20) step();
    chk("smode_masked", 64'(ack_flag), 64'd0);
    mstatus_sie = 1;
    run_event("smode_sie");
    chk("smode_sie_cause", 64'(cap_cause), 64'd9);
    mideleg = '0; mstatus_sie = 0; mode = 2'd3;

`ifdef TRAP_SEQUENCER_WDOG_EN
    pipe_drained = 0; exc_req = 1; exc_cause = 63'd1;
    run_event("wdog");
    chk("wdog_latency", 64'(exc_cyc - ack_cyc), 64'(DRAIN_TIMEOUT + 1));
    chk("wdog_err_set", 64'(wdog_err), 64'd1);
    pipe_drained = 1;
`endif

    pipe_drained = 0; exc_req = 1; exc_cause = 63'd3; exc_pc = 64'h8000_0300;
    clear_flags();
    step();
    chk("rst_drain_ack", 64'(ack_flag), 64'd1);
    repeat (3) step();
    reset = 1;
    #1;
    chk("rst_async_busy", 64'(busy), 64'd0);
    chk("rst_async_stall", 64'(stall), 64'd0);
    step(); step();
    exc_req = 0; reset = 0; pipe_drained = 1;
    step();
    chk("rst_drain_no_strobe", 64'(exc_flag), 64'd0);

    for (int c = 0; c < 3000; c++) begin
      step();
      if (m_acked) begin exc_req = 0; mret_req = 0; sret_req = 0; end
      if (!exc_req && !mret_req && !sret_req && $urandom_range(0, 5) == 0) begin
        t = {$urandom(), $urandom()};
        exc_cause = t[62:0];
        exc_tval  = {$urandom(), $urandom()};
        exc_pc    = {$urandom(), $urandom()};
        exc_req   = ($urandom_range(0, 2) == 0);
        mret_req  = ($urandom_range(0, 2) == 0);
        sret_req  = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 7) == 0)
        irq_pend = ($urandom_range(0, 2) == 0) ? 12'($urandom()) : 12'h0;
      if ($urandom_range(0, 15) == 0) begin
        mideleg     = 12'($urandom());
        mode        = 2'($urandom_range(0, 3));
        mstatus_mie = 1'($urandom_range(0, 1));
        mstatus_sie = 1'($urandom_range(0, 1));
      end
      pipe_drained = ($urandom_range(0, 9) < 6);
    end
    exc_req = 0; mret_req = 0; sret_req = 0; irq_pend = '0; pipe_drained = 1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
